// File: rtl/mic_capture.sv
// Periodic 16-bit serial ADC capture: SCK/CSn framing, 12-bit sample strobe and sticky overrun flag.
// Define MICCAP_ZCHECK_EN to reject frames whose upper nibble is nonzero and pulse o_err instead.
module mic_capture #(
  parameter int unsigned CKDIV       = 5,
  parameter int unsigned SAMPLE_CLKS = 2000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic        o_csn,
  output logic        o_sck,
  input  logic        i_miso,
  output logic        o_valid,
  output logic [11:0] o_data,
  output logic        o_ovrun
`ifdef MICCAP_ZCHECK_EN
  ,
  output logic        o_err
`endif
);

  localparam int unsigned TW = $clog2(SAMPLE_CLKS);
  localparam int unsigned PW = $clog2(2 * CKDIV);
  localparam logic [TW-1:0] TMAX  = TW'(SAMPLE_CLKS - 1);
  localparam logic [PW-1:0] PLAST = PW'(2 * CKDIV - 1);
  localparam logic [PW-1:0] PHIGH = PW'(CKDIV - 1);

  // Only the low 12 bits are ever used unless the upper nibble is checked.
`ifdef MICCAP_ZCHECK_EN
  localparam int unsigned SW = 16;
`else
  localparam int unsigned SW = 12;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [PW-1:0] phase;
  logic [3:0]    bit_cnt;
  logic [SW-1:0] shift_q;
  logic          tick;

  assign tick = i_enable && (timer == TMAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      timer   <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      o_csn   <= 1'b1;
      o_sck   <= 1'b1;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovrun <= 1'b0;
`ifdef MICCAP_ZCHECK_EN
      o_err   <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
`ifdef MICCAP_ZCHECK_EN
      o_err   <= 1'b0;
`endif
      if (!i_enable || timer == TMAX) timer <= '0;
      else                            timer <= timer + 1'b1;

      if (tick && state != IDLE) o_ovrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            state   <= SHIFT;
            o_csn   <= 1'b0;
            o_sck   <= 1'b0;
            phase   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (phase == PLAST) begin
            if (bit_cnt == 4'd15) begin
              state <= QUIET;
              phase <= '0;
              o_csn <= 1'b1;
              o_sck <= 1'b1;
`ifdef MICCAP_ZCHECK_EN
              if (|shift_q[15:12]) begin
                o_err <= 1'b1;
              end else begin
                o_valid <= 1'b1;
                o_data  <= shift_q[11:0];
              end
`else
              o_valid <= 1'b1;
              o_data  <= shift_q[11:0];
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              phase   <= '0;
              o_sck   <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            // Data is taken on the edge that raises SCK.
            if (phase == PHIGH) begin
              o_sck   <= 1'b1;
              shift_q <= {shift_q[SW-2:0], i_miso};
            end
          end
        end
        QUIET: begin
          if (phase == PLAST) state <= IDLE;
          else                phase <= phase + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_capture.sv
// Randomized bench for mic_capture: four parameter sets against a frame-timing reference model
// with an ADC responder per instance.
module tb_mic_capture;

  localparam int NDUT = 4;
  localparam int CKS[NDUT] = '{2, 2, 2, 1};
  localparam int NSS[NDUT] = '{100, 60, 68, 35};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        csn   [NDUT];
  logic        sck   [NDUT];
  logic        miso  [NDUT];
  logic        valid [NDUT];
  logic        ovrun [NDUT];
  logic [11:0] data  [NDUT];
`ifdef MICCAP_ZCHECK_EN
  logic        err   [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mic_capture #(.CKDIV(CKS[g]), .SAMPLE_CLKS(NSS[g])) u_dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_enable (en),
      .o_csn    (csn[g]),
      .o_sck    (sck[g]),
      .i_miso   (miso[g]),
      .o_valid  (valid[g]),
      .o_data   (data[g]),
      .o_ovrun  (ovrun[g])
`ifdef MICCAP_ZCHECK_EN
      ,
      .o_err    (err[g])
`endif
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame position relative to the first CSn-low cycle determines every output.
  int          now;
  int          m_tmr   [NDUT];
  int          m_start [NDUT];
  logic        m_ovr   [NDUT];
  logic [11:0] m_data  [NDUT];
  logic [15:0] m_word  [NDUT];
  logic        fixed_en;
  logic [15:0] fixed_word;

  // ADC responder state
  logic        prev_csn [NDUT];
  logic        prev_sck [NDUT];
  int          a_idx    [NDUT];
  logic [15:0] a_word   [NDUT];

  function automatic logic [15:0] pick_word();
    logic [15:0] w;
    if (fixed_en) return fixed_word;
    w = 16'($urandom);
`ifdef MICCAP_ZCHECK_EN
    if ($urandom_range(1, 0) == 0) w[15:12] = 4'h0;
`endif
    return w;
  endfunction

  task automatic step_cycle();
    int   pos;
    int   c;
    logic tick;
    logic e_csn, e_sck, e_valid, e_err, zbad;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        m_tmr[i] = 0; m_start[i] = -100000; m_ovr[i] = 1'b0; m_data[i] = '0;
      end else begin
        c    = CKS[i];
        pos  = now - m_start[i];
        tick = en && (m_tmr[i] == NSS[i] - 1);
        if (tick) begin
          if (pos < 34 * c) m_ovr[i] = 1'b1;
          else begin
            m_start[i] = now + 1;
            m_word[i]  = pick_word();
          end
        end
        m_tmr[i] = (!en || m_tmr[i] == NSS[i] - 1) ? 0 : m_tmr[i] + 1;
      end
    end
    now = rst ? 0 : now + 1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      c       = CKS[i];
      pos     = now - m_start[i];
      e_csn   = !(pos >= 0 && pos < 32 * c);
      e_sck   = e_csn ? 1'b1 : ((pos % (2 * c)) >= c);
`ifdef MICCAP_ZCHECK_EN
      zbad    = (m_word[i][15:12] != 4'h0);
`else
      zbad    = 1'b0;
`endif
      e_valid = (pos == 32 * c) && !zbad;
      e_err   = (pos == 32 * c) && zbad;
      if (e_valid) m_data[i] = m_word[i][11:0];
      check($sformatf("d%0d csn t=%0d", i, now), 32'(csn[i]), 32'(e_csn));
      check($sformatf("d%0d sck t=%0d", i, now), 32'(sck[i]), 32'(e_sck));
      check($sformatf("d%0d valid t=%0d", i, now), 32'(valid[i]), 32'(e_valid));
      check($sformatf("d%0d data t=%0d", i, now), 32'(data[i]), 32'(m_data[i]));
      check($sformatf("d%0d ovrun t=%0d", i, now), 32'(ovrun[i]), 32'(m_ovr[i]));
`ifdef MICCAP_ZCHECK_EN
      check($sformatf("d%0d err t=%0d", i, now), 32'(err[i]), 32'(e_err));
`else
      if (e_err) check($sformatf("d%0d model_err t=%0d", i, now), 32'(e_err), 32'(0));
`endif
      if (prev_csn[i] && !csn[i]) begin
        a_word[i] = m_word[i];
        a_idx[i]  = 15;
      end else if (!csn[i] && prev_sck[i] && !sck[i] && a_idx[i] > 0) begin
        a_idx[i]--;
      end
      miso[i]     = a_word[i][a_idx[i]];
      prev_csn[i] = csn[i];
      prev_sck[i] = sck[i];
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step_cycle();
    rst = 1'b0;
  endtask

  int first_lo, first_v, first_ov1, first_ov2, rises, nval;

  initial begin
    rst = 1'b1; en = 1'b0; now = 0;
    fixed_en = 1'b1; fixed_word = 16'h0ABC;
    for (int i = 0; i < NDUT; i++) begin
      miso[i] = 1'b0; prev_csn[i] = 1'b1; prev_sck[i] = 1'b1;
      a_idx[i] = 15; a_word[i] = '0; m_word[i] = '0;
      m_tmr[i] = 0; m_start[i] = -100000; m_ovr[i] = 1'b0; m_data[i] = '0;
    end

    // Reset, then first frame with a known word
    do_reset(3);
    en = 1'b1;
    first_lo = -1; first_v = -1; first_ov1 = -1; first_ov2 = -1; rises = 0;
    for (int k = 0; k < 175; k++) begin
      logic was_sck;
      was_sck = sck[0];
      step_cycle();
      if (!csn[0] && first_lo < 0) first_lo = now;
      if (!csn[0] && !was_sck && sck[0]) rises++;
      if (valid[0] && first_v < 0) begin
        first_v = now;
        check("first_data", 32'(data[0]), 32'h0ABC);
      end
      if (ovrun[1] && first_ov1 < 0) first_ov1 = now;
      if (ovrun[2] && first_ov2 < 0) first_ov2 = now;
    end
    check("first_csn_low", 32'(first_lo), 32'd100);
    check("first_valid", 32'(first_v), 32'd164);
    check("sck_rises", 32'(rises), 32'd16);
    check("ovrun_n60", 32'(first_ov1), 32'd120);
    check("ovrun_n68", 32'(first_ov2), 32'd136);
    check("no_ovrun_n35", 32'(ovrun[3]), 32'd0);

    // Continuous run with random words
    fixed_en = 1'b0;
    repeat (400) step_cycle();

    // Reset mid-frame at cycle 130, then resume
    do_reset(2);
    while (now < 130) step_cycle();
    rst = 1'b1;
    step_cycle();
    check("rst_csn", 32'(csn[0]), 32'd1);
    check("rst_sck", 32'(sck[0]), 32'd1);
    rst = 1'b0;
    repeat (250) step_cycle();

    // Enable dropped mid-frame: frame completes, nothing after
    do_reset(2);
    nval = 0;
    while (now < 120) step_cycle();
    en = 1'b0;
    repeat (250) begin
      step_cycle();
      if (valid[0]) begin
        nval++;
        check("late_valid_cyc", 32'(now), 32'd164);
      end
    end
    check("valid_after_disable", 32'(nval), 32'd1);

    // Random enable toggling and occasional resets
    en = 1'b1;
    repeat (2500) begin
      if ($urandom_range(99, 0) < 2) en = ~en;
      rst = ($urandom_range(999, 0) < 3);
      step_cycle();
    end
    rst = 1'b0;
    repeat (100) step_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mic_capture.md
MIC_CAPTURE -- requirements
Module: mic_capture

Interface
REQ-001 SHALL have parameter CKDIV, default 5: SCK half-period in i_clk cycles; legal range 1..255.
REQ-002 SHALL have parameter SAMPLE_CLKS, default 2000: i_clk cycles between conversion starts; legal range 16..65535.
REQ-003 SHALL have port i_clk, input, 1: system clock.
REQ-004 SHALL have port i_reset, input, 1: reset, synchronous, active-high; clock i_clk.
REQ-005 SHALL have port i_enable, input, 1: capture enable.
REQ-006 SHALL have port o_csn, output, 1: ADC chip select, active low.
REQ-007 SHALL have port o_sck, output, 1: ADC serial clock; idles high.
REQ-008 SHALL have port i_miso, input, 1: ADC serial data, MSB first.
REQ-009 SHALL have port o_valid, output, 1: one-cycle sample strobe; drives the FIFO write strobe.
REQ-010 SHALL have port o_data, output, 12: sample value; drives the FIFO write data.
REQ-011 SHALL have port o_ovrun, output, 1: sticky flag; a conversion start arrived while a frame was active.
REQ-012 SHALL have port o_err, output, 1: one-cycle frame-error pulse; exists only with MICCAP_ZCHECK_EN.

Function
REQ-013 SHALL implement states IDLE, SHIFT, QUIET; all outputs SHALL be registered.
REQ-014 Sample timer SHALL count 0..SAMPLE_CLKS-1 while i_enable=1, and wrap to 0.
REQ-015 Sample timer SHALL be held at 0 while i_enable=0.
REQ-016 The timer SHALL generate a tick in the cycle in which it equals SAMPLE_CLKS-1.
REQ-017 A tick in IDLE at cycle T SHALL enter SHIFT, with o_csn=0 from cycle T+1.
REQ-018 SHIFT SHALL run 16 bit periods of 2*CKDIV cycles each: o_sck=0 for the first CKDIV cycles, then o_sck=1 for the last CKDIV cycles.
REQ-019 In each bit period, i_miso SHALL be shifted into a 16-bit register on the cycle o_sck goes 0->1.
REQ-020 At cycle T+1+32*CKDIV: o_csn=1, o_sck=1, o_valid=1, o_data=shift[11:0]; the state SHALL become QUIET.
REQ-021 o_valid SHALL be high for exactly one cycle per frame.
REQ-022 o_data SHALL hold its value until the next o_valid.
REQ-023 QUIET SHALL last 2*CKDIV cycles with o_csn=1, then return to IDLE.
REQ-024 A tick in SHIFT or QUIET SHALL be dropped and SHALL set o_ovrun=1 until reset.
REQ-025 i_enable falling mid-frame SHALL let the current frame complete, including its o_valid.
REQ-026 No new frame SHALL start while i_enable=0.
REQ-027 A tick coinciding with the QUIET->IDLE transition SHALL count as an overrun.

Reset
REQ-028 i_reset SHALL take priority over all other inputs, including mid-frame.
REQ-029 On i_reset: state=IDLE, timer=0, o_csn=1, o_sck=1, o_valid=0, o_data=0, o_ovrun=0, o_err=0.
REQ-030 A frame interrupted by reset SHALL produce no o_valid.

Configuration
REQ-031 With macro MICCAP_ZCHECK_EN defined, shift[15:12] SHALL be checked at frame end; if nonzero, o_valid SHALL stay 0, o_data SHALL be unchanged, and o_err SHALL pulse for one cycle.
REQ-032 Without MICCAP_ZCHECK_EN, shift[15:12] SHALL be ignored, o_valid SHALL pulse every frame, and o_err SHALL not exist.

Verification (CKDIV=2, SAMPLE_CLKS=100, ADC model on o_csn/o_sck)
REQ-033 Reset, i_enable=1, ADC word 16'h0ABC -> first tick at cycle 99, o_csn low cycles 100..163, o_valid at 164 with o_data=12'hABC; o_sck shows 16 low/high pairs of 2 cycles each.
REQ-034 Continuous run, words 16'h0FFF then 16'h0000 -> o_valid pulses 100 cycles apart, o_data=12'hFFF then 12'h000, o_ovrun=0.
REQ-035 SAMPLE_CLKS=60 -> second tick falls in SHIFT; o_ovrun=1 from that cycle, that frame is skipped, the next valid tick captures normally.
REQ-036 Assert i_reset at cycle 130 mid-frame -> o_csn=1 and o_sck=1 next cycle, no o_valid; capture resumes 100 cycles after reset release.
REQ-037 Drop i_enable at cycle 120 -> o_valid still at 164, then no further o_csn activity.
REQ-038 With MICCAP_ZCHECK_EN, word 16'h8ABC -> o_err pulse at 164, o_valid=0, o_data retains its prior value.
